commutative_checker: RTL and testbench
======================================

# commutative_checker

Self-test sequencer for the gate-level commutative-law datapath (AND/OR left-hand vs right-hand instances). On a start request it enumerates every operand combination, drives the datapath, waits a programmable settle time, compares the LHS and RHS results of each law, and accumulates a mismatch count plus the first failing vector. It sits beside the datapath as its only stimulus source, replacing the hand-written stimulus sequence.

## Interface
- `W`, 1: operand width in bits. Vector count V = 2^(2W).
- `SETTLE`, 1: cycles each vector is held before it is checked. Must be ≥ 1.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `abort`  in  1  cancel a running sweep.
- `and_lhs`, `and_rhs`, `or_lhs`, `or_rhs`  in  W each  datapath results.
- `a_o`, `b_o`  out  W each  operands driven to the datapath.
- `busy`  out  1  high in WAIT and CHECK.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `pass`  out  1  last completed sweep had zero mismatches.
- `err_cnt`  out  2W+1  mismatching vectors in current/last sweep.
- `fail_valid`  out  1  `fail_a`/`fail_b` hold a captured vector.
- `fail_a`, `fail_b`  out  W each  operands of first mismatching vector.

## Operation
- All outputs registered. Reset value of every output and internal register: 0; state = IDLE.
- Vector counter `vec` (2W bits): `a_o = vec[W-1:0]`, `b_o = vec[2W-1:W]`; sweep order 0 → V-1.
- States:
  - IDLE: `start`=1 → clear `vec`, `err_cnt`, `fail_valid`, `fail_a`, `fail_b`, `pass`; load settle counter with SETTLE-1; go WAIT.
  - WAIT: operands held; settle counter decrements; at 0 → CHECK.
  - CHECK: mismatch = (`and_lhs`≠`and_rhs`) OR (`or_lhs`≠`or_rhs`), compared bitwise on all W bits. On mismatch: `err_cnt`+1; if `fail_valid`=0, capture `a_o`/`b_o` and set `fail_valid`. If `vec`=V-1 → DONE, else `vec`+1, reload settle counter, → WAIT.
  - DONE: `done`=1, `pass` = (`err_cnt`=0, including this last check); → IDLE next cycle.
- `err_cnt` width holds V exactly; it never saturates or wraps.
- `start` while not in IDLE: ignored.
- `abort` in WAIT or CHECK: → IDLE next edge; no `done` pulse, `pass` stays 0, the CHECK in progress is not counted; `err_cnt` and `fail_*` keep partial values. `abort` in IDLE or DONE: ignored (DONE still completes). `abort` and `start` together in IDLE: start wins.
- Results (`pass`, `err_cnt`, `fail_*`) hold in IDLE until the next accepted `start`.
- `rst_n` low at any time, including mid-sweep: immediate return to reset values; no `done`.

## Timing
- `start` sampled at edge t0 → `busy`=1 and `a_o`/`b_o`=vector 0 after t0.
- Each vector occupies SETTLE+1 cycles (SETTLE in WAIT, 1 in CHECK). Datapath outputs are sampled at the CHECK-cycle edge, i.e. SETTLE+1 cycles after the operands change.
- `done` high for exactly the cycle following edge t0 + V·(SETTLE+1). `busy` low in that cycle.
- Earliest next `start` is sampled 2 cycles after `done` rises (DONE → IDLE).
- W=1, SETTLE=1: V=4, `done` high after edge t0+8.

## Test plan
- W=1, SETTLE=1, correct gate datapath, pulse `start` → vectors (a,b) = 00,10,01,11; `done` after edge t0+8; `pass`=1, `err_cnt`=0, `fail_valid`=0.
- `and_rhs` stuck at 0 → only a=1,b=1 fails; `err_cnt`=1, `fail_a`=1, `fail_b`=1, `pass`=0.
- `or_rhs` stuck at 0 → vectors 10, 01 and 11 fail; `err_cnt`=3, first fail `fail_a`=1, `fail_b`=0.
- SETTLE=3, W=2, correct datapath → 16 vectors, `done` after edge t0+64, `err_cnt`=0; `start` re-pulsed mid-sweep is ignored, so the timing is unchanged.
- `abort` at edge t0+3 → IDLE, `busy`=0, no `done`, `pass`=0. A new `start` then runs a full clean sweep with `pass`=1.
- `rst_n` low asynchronously mid-WAIT → all outputs 0 immediately (before the next edge). After release, state is IDLE, and `start` behaves as in the first scenario.

Source files
------------

// File: rtl/commutative_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : commutative_checker_if
// Purpose  : Bundle between the commutative-law self-test sequencer and the
//            gate-level AND/OR datapath plus its control/status consumer.
// Revision : 1.0  initial release
// ============================================================================
interface commutative_checker_if #(
  parameter int W = 1
);
  // control requests into the sequencer
  logic           start;
  logic           abort;
  // datapath results (LHS/RHS instances of each law)
  logic [W-1:0]   and_lhs;
  logic [W-1:0]   and_rhs;
  logic [W-1:0]   or_lhs;
  logic [W-1:0]   or_rhs;
  // operands driven to the datapath
  logic [W-1:0]   a_o;
  logic [W-1:0]   b_o;
  // sweep status and results
  logic           busy;
  logic           done;
  logic           pass;
  logic [2*W:0]   err_cnt;
  logic           fail_valid;
  logic [W-1:0]   fail_a;
  logic [W-1:0]   fail_b;

  // master: the environment (requester + datapath)
  modport master (
    output start, abort, and_lhs, and_rhs, or_lhs, or_rhs,
    input  a_o, b_o, busy, done, pass, err_cnt, fail_valid, fail_a, fail_b
  );

  // slave: the self-test sequencer
  modport slave (
    input  start, abort, and_lhs, and_rhs, or_lhs, or_rhs,
    output a_o, b_o, busy, done, pass, err_cnt, fail_valid, fail_a, fail_b
  );
endinterface
`default_nettype wire

// File: rtl/commutative_checker.sv
`default_nettype none
// ============================================================================
// Module   : commutative_checker
// Purpose  : Sweeps every (a,b) operand pair through the commutative-law
//            datapath, waits SETTLE cycles per vector, compares LHS vs RHS of
//            both laws and accumulates a mismatch count and first failure.
// Revision : 1.0  initial release
// ============================================================================
module commutative_checker #(
  parameter int W      = 1,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  commutative_checker_if.slave bus
);

  // settle counter only ever holds SETTLE-1 down to 0
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state;
  logic [2*W-1:0] vec;
  logic [CW-1:0]  settle_cnt;
  logic           busy_r;
  logic           done_r;
  logic           pass_r;
  logic [2*W:0]   err_cnt_r;
  logic           fail_valid_r;
  logic [W-1:0]   fail_a_r;
  logic [W-1:0]   fail_b_r;
  logic           mismatch;

  // any bit differing on either law marks the vector as failing
  always_comb begin
    mismatch = (bus.and_lhs != bus.and_rhs) || (bus.or_lhs != bus.or_rhs);
  end

  // sweep sequencer: every status output is a register written here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      vec          <= '0;
      settle_cnt   <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_cnt_r    <= '0;
      fail_valid_r <= 1'b0;
      fail_a_r     <= '0;
      fail_b_r     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // start outranks a simultaneous abort; results hold otherwise
          if (bus.start) begin
            vec          <= '0;
            err_cnt_r    <= '0;
            fail_valid_r <= 1'b0;
            fail_a_r     <= '0;
            fail_b_r     <= '0;
            pass_r       <= 1'b0;
            settle_cnt   <= SETTLE_LOAD;
            busy_r       <= 1'b1;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.abort) begin
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end else if (settle_cnt == '0) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt - CW'(1);
          end
        end
        S_CHECK: begin
          // an abort discards the comparison taking place this cycle
          if (bus.abort) begin
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end else begin
            if (mismatch) begin
              err_cnt_r <= err_cnt_r + (2*W+1)'(1);
              if (!fail_valid_r) begin
                fail_valid_r <= 1'b1;
                fail_a_r     <= vec[W-1:0];
                fail_b_r     <= vec[2*W-1:W];
              end
            end
            if (&vec) begin
              busy_r <= 1'b0;
              done_r <= 1'b1;
              // include the verdict of this final vector
              pass_r <= !mismatch && (err_cnt_r == '0);
              state  <= S_DONE;
            end else begin
              vec        <= vec + (2*W)'(1);
              settle_cnt <= SETTLE_LOAD;
              state      <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          done_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.a_o        = vec[W-1:0];
  assign bus.b_o        = vec[2*W-1:W];
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.pass       = pass_r;
  assign bus.err_cnt    = err_cnt_r;
  assign bus.fail_valid = fail_valid_r;
  assign bus.fail_a     = fail_a_r;
  assign bus.fail_b     = fail_b_r;

endmodule
`default_nettype wire

// File: tb/tb_commutative_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_commutative_checker
// Purpose  : Self-checking bench for commutative_checker: two instances
//            (W=1/SETTLE=1 and W=2/SETTLE=3) driven by a behavioural
//            datapath with injectable stuck-at and random per-vector faults.
// Revision : 1.0  initial release
// ============================================================================
module tb_commutative_checker;

  localparam int W1 = 1;
  localparam int S1 = 1;
  localparam int W2 = 2;
  localparam int S2 = 3;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic sel;          // 0 -> instance 1, 1 -> instance 2

  // datapath fault injection
  bit         stuck_and;
  bit         stuck_or;
  logic [1:0] flip_and [16];
  logic [1:0] flip_or  [16];

  int total;
  int bad;

  // expected results from the reference model
  int exp_err;
  int exp_fa;
  int exp_fb;
  int exp_fv;

  commutative_checker_if #(.W(W1)) bus1 ();
  commutative_checker_if #(.W(W2)) bus2 ();

  commutative_checker #(.W(W1), .SETTLE(S1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  commutative_checker #(.W(W2), .SETTLE(S2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus1.start = start & ~sel;
  assign bus1.abort = abort & ~sel;
  assign bus2.start = start & sel;
  assign bus2.abort = abort & sel;

  // behavioural gate datapath for instance 1 with optional faults
  always_comb begin
    bus1.and_lhs = bus1.a_o & bus1.b_o;
    bus1.or_lhs  = bus1.a_o | bus1.b_o;
    bus1.and_rhs = stuck_and ? 1'b0 :
                   ((bus1.b_o & bus1.a_o) ^ flip_and[int'({bus1.b_o, bus1.a_o})][0]);
    bus1.or_rhs  = stuck_or ? 1'b0 :
                   ((bus1.b_o | bus1.a_o) ^ flip_or[int'({bus1.b_o, bus1.a_o})][0]);
  end

  // behavioural gate datapath for instance 2 with optional faults
  always_comb begin
    bus2.and_lhs = bus2.a_o & bus2.b_o;
    bus2.or_lhs  = bus2.a_o | bus2.b_o;
    bus2.and_rhs = stuck_and ? 2'b00 :
                   ((bus2.b_o & bus2.a_o) ^ flip_and[int'({bus2.b_o, bus2.a_o})]);
    bus2.or_rhs  = stuck_or ? 2'b00 :
                   ((bus2.b_o | bus2.a_o) ^ flip_or[int'({bus2.b_o, bus2.a_o})]);
  end

  // observation mux onto common widths
  logic       obs_busy, obs_done, obs_pass, obs_fv;
  logic [4:0] obs_err;
  logic [3:0] obs_vec;
  logic [1:0] obs_fa, obs_fb;

  // pick the instance currently under test
  always_comb begin
    if (sel) begin
      obs_busy = bus2.busy;
      obs_done = bus2.done;
      obs_pass = bus2.pass;
      obs_fv   = bus2.fail_valid;
      obs_err  = bus2.err_cnt;
      obs_vec  = {bus2.b_o, bus2.a_o};
      obs_fa   = bus2.fail_a;
      obs_fb   = bus2.fail_b;
    end else begin
      obs_busy = bus1.busy;
      obs_done = bus1.done;
      obs_pass = bus1.pass;
      obs_fv   = bus1.fail_valid;
      obs_err  = 5'(bus1.err_cnt);
      obs_vec  = 4'({bus1.b_o, bus1.a_o});
      obs_fa   = 2'(bus1.fail_a);
      obs_fb   = 2'(bus1.fail_b);
    end
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // reference: which of the first 'upto' vectors disagree between LHS and RHS
  task automatic model(input int w, input int upto);
    int mask;
    int a, b, al, ar, ol, orr;
    mask    = (1 << w) - 1;
    exp_err = 0;
    exp_fa  = 0;
    exp_fb  = 0;
    for (int v = 0; v < upto; v++) begin
      a   = v & mask;
      b   = (v >> w) & mask;
      al  = a & b;
      ol  = a | b;
      ar  = stuck_and ? 0 : ((b & a) ^ (int'(flip_and[v]) & mask));
      orr = stuck_or  ? 0 : ((b | a) ^ (int'(flip_or[v])  & mask));
      if (al != ar || ol != orr) begin
        if (exp_err == 0) begin
          exp_fa = a;
          exp_fb = b;
        end
        exp_err++;
      end
    end
    exp_fv = (exp_err > 0) ? 1 : 0;
  endtask

  task automatic clear_faults();
    stuck_and = 1'b0;
    stuck_or  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      flip_and[i] = 2'b00;
      flip_or[i]  = 2'b00;
    end
  endtask

  task automatic random_faults();
    for (int i = 0; i < 16; i++) begin
      flip_and[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      flip_or[i]  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ":busy"},  32'(obs_busy), 0);
    check({tag, ":done"},  32'(obs_done), 0);
    check({tag, ":pass"},  32'(obs_pass), 0);
    check({tag, ":err"},   32'(obs_err),  0);
    check({tag, ":fv"},    32'(obs_fv),   0);
    check({tag, ":fa"},    32'(obs_fa),   0);
    check({tag, ":fb"},    32'(obs_fb),   0);
    check({tag, ":vec"},   32'(obs_vec),  0);
  endtask

  // one sweep; abort_at>0 asserts abort so it is sampled at edge t0+abort_at
  task automatic run_sweep(input string tag, input bit s_sel, input int abort_at,
                           input bit repulse, input bit start_with_abort);
    int w, s, nv, cyc, upto;
    w   = s_sel ? W2 : W1;
    s   = s_sel ? S2 : S1;
    nv  = 1 << (2 * w);
    cyc = nv * (s + 1);
    sel = s_sel;
    @(negedge clk);
    start = 1'b1;
    abort = start_with_abort;
    @(negedge clk);                     // edge t0 has passed
    start = 1'b0;
    abort = 1'b0;
    check({tag, ":busy_t0"}, 32'(obs_busy), 1);
    check({tag, ":vec_t0"},  32'(obs_vec),  0);
    check({tag, ":err_t0"},  32'(obs_err),  0);
    for (int k = 1; k <= cyc; k++) begin
      if (repulse && k == 5) start = 1'b1;
      if (abort_at == k) abort = 1'b1;
      @(negedge clk);                   // edge t0+k has passed
      start = 1'b0;
      abort = 1'b0;
      if (abort_at != 0 && k == abort_at) begin
        upto = 0;
        while (upto < nv && (upto + 1) * (s + 1) < abort_at) upto++;
        model(w, upto);
        check({tag, ":ab_busy"}, 32'(obs_busy), 0);
        check({tag, ":ab_done"}, 32'(obs_done), 0);
        check({tag, ":ab_pass"}, 32'(obs_pass), 0);
        check({tag, ":ab_err"},  32'(obs_err),  32'(exp_err));
        check({tag, ":ab_fv"},   32'(obs_fv),   32'(exp_fv));
        if (exp_fv != 0) begin
          check({tag, ":ab_fa"}, 32'(obs_fa), 32'(exp_fa));
          check({tag, ":ab_fb"}, 32'(obs_fb), 32'(exp_fb));
        end
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          check({tag, ":ab_nodone"}, 32'(obs_done), 0);
        end
        return;
      end
      if (k < cyc) begin
        check({tag, ":busy"}, 32'(obs_busy), 1);
        check({tag, ":done_early"}, 32'(obs_done), 0);
        check({tag, ":vec"}, 32'(obs_vec), 32'(k / (s + 1)));
      end else begin
        model(w, nv);
        check({tag, ":done"},   32'(obs_done), 1);
        check({tag, ":busy_d"}, 32'(obs_busy), 0);
        check({tag, ":pass"},   32'(obs_pass), (exp_err == 0) ? 1 : 0);
        check({tag, ":err"},    32'(obs_err),  32'(exp_err));
        check({tag, ":fv"},     32'(obs_fv),   32'(exp_fv));
        check({tag, ":fa"},     32'(obs_fa),   32'(exp_fa));
        check({tag, ":fb"},     32'(obs_fb),   32'(exp_fb));
      end
    end
    @(negedge clk);
    check({tag, ":done_pulse"}, 32'(obs_done), 0);
    repeat (2) @(negedge clk);
    check({tag, ":hold_err"},  32'(obs_err),  32'(exp_err));
    check({tag, ":hold_pass"}, 32'(obs_pass), (exp_err == 0) ? 1 : 0);
    check({tag, ":hold_busy"}, 32'(obs_busy), 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    sel   = 1'b0;
    clear_faults();

    // reset state of both instances
    #12;
    sel = 1'b0;
    #1 check_idle_zero("rst1");
    sel = 1'b1;
    #1 check_idle_zero("rst2");
    @(negedge clk);
    rst_n = 1'b1;

    // clean sweep, then the two stuck-at faults
    run_sweep("clean1", 1'b0, 0, 1'b0, 1'b0);
    stuck_and = 1'b1;
    run_sweep("and_stuck", 1'b0, 0, 1'b0, 1'b1);
    check("and_stuck_cnt", 32'(exp_err), 1);
    stuck_and = 1'b0;
    stuck_or  = 1'b1;
    run_sweep("or_stuck", 1'b0, 0, 1'b0, 1'b0);
    check("or_stuck_cnt", 32'(exp_err), 3);
    clear_faults();

    // wide instance with start re-pulsed mid-sweep
    run_sweep("clean2", 1'b1, 0, 1'b1, 1'b0);

    // random per-vector faults on both instances
    for (int it = 0; it < 3; it++) begin
      random_faults();
      run_sweep("rand2", 1'b1, 0, 1'b0, 1'b0);
      run_sweep("rand1", 1'b0, 0, 1'b0, 1'b0);
    end

    // abort at t0+3 then a clean sweep
    clear_faults();
    run_sweep("abort1", 1'b0, 3, 1'b0, 1'b0);
    run_sweep("post_abort", 1'b0, 0, 1'b0, 1'b0);

    // random abort point with random faults on the wide instance
    random_faults();
    run_sweep("abort2", 1'b1, int'($urandom_range(1, 64)), 1'b0, 1'b0);

    // leave results behind, then reset asynchronously mid-WAIT
    run_sweep("pre_rst", 1'b1, 0, 1'b0, 1'b0);
    clear_faults();
    stuck_or = 1'b1;
    sel = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);          // third vector, WAIT phase
    check("mid_busy", 32'(obs_busy), 1);
    #1 rst_n = 1'b0;
    #1 check_idle_zero("async_rst");
    sel = 1'b0;
    #1 check_idle_zero("async_rst1");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_busy", 32'(obs_busy), 0);
    clear_faults();
    run_sweep("after_rst", 1'b0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
